systolic_array_controller: RTL and testbench

//   Sequences one systolic_array job: loads SA_ROWS weight rows, streams

---
 rtl/systolic_array_controller_if.sv | 70 +++++++
 rtl/systolic_array_controller.sv | 185 ++++++++++++++++++
 tb/tb_systolic_array_controller.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_array_controller_if.sv
`default_nettype none
// ============================================================================
// systolic_array_controller_if : job control, weight/activation streams,
// array-side and result buses for systolic_array_controller.
// Optional reuse_weights_in exists when SA_CTRL_WEIGHT_REUSE_EN is defined.
// Revision: 1.0
// ============================================================================
interface systolic_array_controller_if #(
  parameter int ROWS        = 8,
  parameter int COLS        = 8,
  parameter int FPW         = 16,
  parameter int BATCH_WIDTH = 8
);
  logic                   start_in;
  logic [BATCH_WIDTH-1:0] batch_len_in;
`ifdef SA_CTRL_WEIGHT_REUSE_EN
  logic                   reuse_weights_in;
`endif
  logic                   busy_out;
  logic                   done_out;

  logic                   wt_valid_in;
  logic                   wt_ready_out;
  logic [COLS*FPW-1:0]    wt_data_in;

  logic                   act_valid_in;
  logic                   act_ready_out;
  logic [ROWS*FPW-1:0]    act_data_in;

  logic                   sa_weights_valid_out;
  logic [COLS*FPW-1:0]    sa_weights_out;
  logic [ROWS*FPW-1:0]    sa_activations_out;
  logic [COLS*FPW-1:0]    sa_sum_in;

  logic                   res_valid_out;
  logic [COLS*FPW-1:0]    res_data_out;

  // Controller side
  modport slave (
`ifdef SA_CTRL_WEIGHT_REUSE_EN
    input  reuse_weights_in,
`endif
    input  start_in, batch_len_in,
    output busy_out, done_out,
    input  wt_valid_in, wt_data_in,
    output wt_ready_out,
    input  act_valid_in, act_data_in,
    output act_ready_out,
    output sa_weights_valid_out, sa_weights_out, sa_activations_out,
    input  sa_sum_in,
    output res_valid_out, res_data_out
  );

  // Scheduler / SRAM / array side
  modport master (
`ifdef SA_CTRL_WEIGHT_REUSE_EN
    output reuse_weights_in,
`endif
    output start_in, batch_len_in,
    input  busy_out, done_out,
    output wt_valid_in, wt_data_in,
    input  wt_ready_out,
    output act_valid_in, act_data_in,
    input  act_ready_out,
    input  sa_weights_valid_out, sa_weights_out, sa_activations_out,
    output sa_sum_in,
    input  res_valid_out, res_data_out
  );
endinterface
`default_nettype wire

// File: rtl/systolic_array_controller.sv
`default_nettype none
// ============================================================================
// systolic_array_controller : sequences one systolic-array job (weight load,
// skewed activation stream, result deskew). Optional: SA_CTRL_WEIGHT_REUSE_EN.
// Revision: 1.0
// ============================================================================
module systolic_array_controller #(
  parameter int SYSTOLIC_ARRAY_ROWS = 8,
  parameter int SYSTOLIC_ARRAY_COLS = 8,
  parameter int FIXED_POINT_WIDTH   = 16,
  parameter int SA_LATENCY          = 8,
  parameter int BATCH_WIDTH         = 8
) (
  input  wire logic                   clk_in,
  input  wire logic                   rst_n_in,
  systolic_array_controller_if.slave  bus
);

  localparam int C_ROWS      = SYSTOLIC_ARRAY_ROWS;
  localparam int C_COLS      = SYSTOLIC_ARRAY_COLS;
  localparam int C_FPW       = FIXED_POINT_WIDTH;
  localparam int C_VLD_DEPTH = SA_LATENCY + C_COLS + 1;
  localparam int C_RCNT_W    = $clog2(C_ROWS + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [C_RCNT_W-1:0]     row_cnt_q, row_cnt_d;
  logic [BATCH_WIDTH-1:0]  act_cnt_q, act_cnt_d;
  logic [BATCH_WIDTH-1:0]  batch_len_q, batch_len_d;
  logic [C_VLD_DEPTH-1:0]  vld_q;
  logic                    wvalid_q;
  logic [C_COLS*C_FPW-1:0] wdata_q;
`ifdef SA_CTRL_WEIGHT_REUSE_EN
  logic                    wloaded_q, wloaded_d;
`endif

  logic                    wt_ready;
  logic                    act_ready;
  logic                    wt_hs;
  logic                    act_hs;
  logic                    row_last;
  logic                    act_last;
  logic [C_ROWS*C_FPW-1:0] skew_vec;
  logic [C_COLS*C_FPW-1:0] deskew_vec;

  assign wt_ready  = (state_q == ST_LOAD_W);
  assign act_ready = (state_q == ST_STREAM) && (act_cnt_q < batch_len_q);
  assign wt_hs     = bus.wt_valid_in  & wt_ready;
  assign act_hs    = bus.act_valid_in & act_ready;
  assign row_last  = (row_cnt_q == C_RCNT_W'(C_ROWS - 1));
  assign act_last  = (act_cnt_q == (batch_len_q - BATCH_WIDTH'(1)));

  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    act_cnt_d   = act_cnt_q;
    batch_len_d = batch_len_q;
`ifdef SA_CTRL_WEIGHT_REUSE_EN
    wloaded_d   = wloaded_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start_in) begin
          batch_len_d = bus.batch_len_in;
          row_cnt_d   = '0;
          act_cnt_d   = '0;
`ifdef SA_CTRL_WEIGHT_REUSE_EN
          // Resident weights are only trusted after a complete load since reset
          if (bus.reuse_weights_in && wloaded_q)
            state_d = (bus.batch_len_in == '0) ? ST_DONE : ST_STREAM;
          else
            state_d = ST_LOAD_W;
`else
          state_d = ST_LOAD_W;
`endif
        end
      end
      ST_LOAD_W: begin
        if (wt_hs) begin
          if (row_last) begin
            row_cnt_d = C_RCNT_W'(C_ROWS);
            state_d   = (batch_len_q == '0) ? ST_DONE : ST_STREAM;
`ifdef SA_CTRL_WEIGHT_REUSE_EN
            wloaded_d = 1'b1;
`endif
          end else begin
            row_cnt_d = row_cnt_q + C_RCNT_W'(1);
          end
        end
      end
      ST_STREAM: begin
        if (act_hs) begin
          act_cnt_d = act_cnt_q + BATCH_WIDTH'(1);
          if (act_last) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Leave when only the final stage (if any) is still occupied, so DONE
        // lands one cycle after the last result.
        if (vld_q[C_VLD_DEPTH-2:0] == '0) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q     <= ST_IDLE;
      row_cnt_q   <= '0;
      act_cnt_q   <= '0;
      batch_len_q <= '0;
      vld_q       <= '0;
      wvalid_q    <= 1'b0;
      wdata_q     <= '0;
`ifdef SA_CTRL_WEIGHT_REUSE_EN
      wloaded_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      act_cnt_q   <= act_cnt_d;
      batch_len_q <= batch_len_d;
      vld_q       <= {vld_q[C_VLD_DEPTH-2:0], act_hs};
      wvalid_q    <= wt_hs;
      wdata_q     <= wt_hs ? bus.wt_data_in : '0;
`ifdef SA_CTRL_WEIGHT_REUSE_EN
      wloaded_q   <= wloaded_d;
`endif
    end
  end

  // Lane r sits behind r+1 registers; gaps in the stream inject zeros.
  for (genvar r = 0; r < C_ROWS; r++) begin : g_skew
    localparam int C_DEPTH = r + 1;
    logic [C_FPW-1:0] skew_q [C_DEPTH];

    always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
        for (int k = 0; k < C_DEPTH; k++) skew_q[k] <= '0;
      end else begin
        skew_q[0] <= act_hs ? bus.act_data_in[r*C_FPW +: C_FPW] : '0;
        for (int k = 1; k < C_DEPTH; k++) skew_q[k] <= skew_q[k-1];
      end
    end

    assign skew_vec[r*C_FPW +: C_FPW] = skew_q[C_DEPTH-1];
  end

  // Column c waits COLS-1-c cycles plus one output register.
  for (genvar c = 0; c < C_COLS; c++) begin : g_deskew
    localparam int C_DEPTH = C_COLS - c;
    logic [C_FPW-1:0] dsk_q [C_DEPTH];

    always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
        for (int k = 0; k < C_DEPTH; k++) dsk_q[k] <= '0;
      end else begin
        dsk_q[0] <= bus.sa_sum_in[c*C_FPW +: C_FPW];
        for (int k = 1; k < C_DEPTH; k++) dsk_q[k] <= dsk_q[k-1];
      end
    end

    assign deskew_vec[c*C_FPW +: C_FPW] = dsk_q[C_DEPTH-1];
  end

  assign bus.busy_out             = (state_q != ST_IDLE);
  assign bus.done_out             = (state_q == ST_DONE);
  assign bus.wt_ready_out         = wt_ready;
  assign bus.act_ready_out        = act_ready;
  assign bus.sa_weights_valid_out = wvalid_q;
  assign bus.sa_weights_out       = wdata_q;
  assign bus.sa_activations_out   = skew_vec;
  assign bus.res_valid_out        = vld_q[C_VLD_DEPTH-1];
  assign bus.res_data_out         = vld_q[C_VLD_DEPTH-1] ? deskew_vec : '0;

endmodule
`default_nettype wire

// File: tb/tb_systolic_array_controller.sv
`default_nettype none
// ============================================================================
// tb_systolic_array_controller : randomized bench with a matmul reference and
// an ideal-array timing model driving sa_sum_in. Revision: 1.0
// ============================================================================
module tb_systolic_array_controller;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int FPW  = 16;
  localparam int LAT  = 8;
  localparam int BW   = 8;
  localparam int D    = LAT + COLS + 1;
  localparam int MAXC = 16384;
`ifdef SA_CTRL_WEIGHT_REUSE_EN
  localparam int REUSE_WT = 0;
`else
  localparam int REUSE_WT = ROWS;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  systolic_array_controller_if #(.ROWS(ROWS), .COLS(COLS), .FPW(FPW), .BATCH_WIDTH(BW)) bus ();

  systolic_array_controller #(
    .SYSTOLIC_ARRAY_ROWS(ROWS), .SYSTOLIC_ARRAY_COLS(COLS), .FIXED_POINT_WIDTH(FPW),
    .SA_LATENCY(LAT), .BATCH_WIDTH(BW)
  ) dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  int cyc     = 0;
  int hist_lo = 0;
  bit                   act_v [MAXC];
  logic [ROWS*FPW-1:0]  act_d [MAXC];
  logic [COLS*FPW-1:0]  act_y [MAXC];
  logic [FPW-1:0]       wm [ROWS][COLS];
  int  wrow = 0;
  int  tot_wt = 0, tot_act = 0, tot_res = 0, tot_done = 0;
  int  last_act_cyc = 0, last_res_cyc = 0, done_cyc = 0;
  bit  prev_wt_hs = 1'b0;
  logic [COLS*FPW-1:0] prev_wt_data = '0;
  bit  wt_hs_f = 1'b0, act_hs_f = 1'b0;
  int  wt_pct = 100, act_pct = 100;
  bit  act_pat = 1'b0;

  task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: y[c] = sum_r a[r] * W[r][c], modulo 2^FPW
  function automatic logic [COLS*FPW-1:0] matmul(input logic [ROWS*FPW-1:0] a);
    logic [COLS*FPW-1:0] y;
    logic [FPW-1:0] acc;
    for (int c = 0; c < COLS; c++) begin
      acc = '0;
      for (int r = 0; r < ROWS; r++) acc = acc + FPW'(a[r*FPW +: FPW] * wm[r][c]);
      y[c*FPW +: FPW] = acc;
    end
    return y;
  endfunction

  // Monitor, per-cycle checks, and ideal array model
  initial begin
    int t;
    logic [ROWS*FPW-1:0] exp_act;
    logic [COLS*FPW-1:0] sum;
    bit exp_rv;
    bus.sa_sum_in = '0;
    forever begin
      @(negedge clk);
      if (cyc >= MAXC) begin
        $display("FAIL cycle_budget: got %0d expected < %0d", cyc, MAXC);
        $fatal(1);
      end
      if (!rst_n) begin
        hist_lo    = cyc + 1;
        wrow       = 0;
        prev_wt_hs = 1'b0;
        wt_hs_f    = 1'b0;
        act_hs_f   = 1'b0;
        act_v[cyc] = 1'b0;
      end else begin
        chk_eq("sa_wvalid", 128'(bus.sa_weights_valid_out), 128'(prev_wt_hs));
        if (prev_wt_hs) chk_eq("sa_weights", 128'(bus.sa_weights_out), 128'(prev_wt_data));
        exp_act = '0;
        for (int r = 0; r < ROWS; r++) begin
          t = cyc - 1 - r;
          if (t >= hist_lo && t >= 0 && act_v[t]) exp_act[r*FPW +: FPW] = act_d[t][r*FPW +: FPW];
        end
        chk_eq("sa_act", 128'(bus.sa_activations_out), 128'(exp_act));
        t = cyc - D;
        exp_rv = (t >= hist_lo && t >= 0) ? act_v[t] : 1'b0;
        chk_eq("res_valid", 128'(bus.res_valid_out), 128'(exp_rv));
        chk_eq("res_data", 128'(bus.res_data_out), exp_rv ? 128'(act_y[t]) : 128'(0));
        if (bus.res_valid_out) begin tot_res++; last_res_cyc = cyc; end
        if (bus.done_out) begin tot_done++; done_cyc = cyc; end

        wt_hs_f = bus.wt_valid_in & bus.wt_ready_out;
        if (wt_hs_f) begin
          for (int c = 0; c < COLS; c++) wm[wrow][c] = bus.wt_data_in[c*FPW +: FPW];
          wrow = (wrow + 1) % ROWS;
          tot_wt++;
        end
        prev_wt_hs   = wt_hs_f;
        prev_wt_data = bus.wt_data_in;

        act_hs_f   = bus.act_valid_in & bus.act_ready_out;
        act_v[cyc] = act_hs_f;
        if (act_hs_f) begin
          act_d[cyc]   = bus.act_data_in;
          act_y[cyc]   = matmul(bus.act_data_in);
          tot_act++;
          last_act_cyc = cyc;
        end
      end
      // Column c of the result for a vector accepted at T appears at T+1+LAT+c
      for (int c = 0; c < COLS; c++) begin
        t = cyc - 1 - LAT - c;
        if (rst_n && t >= hist_lo && t >= 0 && act_v[t]) sum[c*FPW +: FPW] = act_y[t][c*FPW +: FPW];
        else sum[c*FPW +: FPW] = FPW'($urandom);
      end
      bus.sa_sum_in = sum;
      cyc++;
    end
  end

  // Stream drivers: payload held until accepted
  initial begin
    logic [ROWS*FPW-1:0] v;
    bus.wt_valid_in  = 1'b0;
    bus.wt_data_in   = '0;
    bus.act_valid_in = 1'b0;
    bus.act_data_in  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!bus.wt_valid_in || wt_hs_f) begin
        bus.wt_valid_in = ($urandom_range(99) < 32'(wt_pct));
        for (int c = 0; c < COLS; c++) bus.wt_data_in[c*FPW +: FPW] = FPW'($urandom);
      end
      if (!bus.act_valid_in || act_hs_f) begin
        bus.act_valid_in = ($urandom_range(99) < 32'(act_pct));
        for (int r = 0; r < ROWS; r++)
          v[r*FPW +: FPW] = act_pat ? FPW'(r + 1) : FPW'($urandom);
        bus.act_data_in = v;
      end
    end
  end

  task automatic chk_reset_outputs();
    @(negedge clk);
    #1;
    chk_eq("rst_busy",      128'(bus.busy_out),             128'(0));
    chk_eq("rst_done",      128'(bus.done_out),             128'(0));
    chk_eq("rst_wt_ready",  128'(bus.wt_ready_out),         128'(0));
    chk_eq("rst_act_ready", 128'(bus.act_ready_out),        128'(0));
    chk_eq("rst_sa_wvalid", 128'(bus.sa_weights_valid_out), 128'(0));
    chk_eq("rst_sa_wdata",  128'(bus.sa_weights_out),       128'(0));
    chk_eq("rst_sa_act",    128'(bus.sa_activations_out),   128'(0));
    chk_eq("rst_res_valid", 128'(bus.res_valid_out),        128'(0));
    chk_eq("rst_res_data",  128'(bus.res_data_out),         128'(0));
  endtask

  task automatic run_job(input int len, input int pct, input bit poke, input bit reuse, input int exp_wt);
    int s_wt, s_act, s_res, s_done;
    bit got;
    wt_pct  = pct;
    act_pct = pct;
    @(posedge clk);
    #1;
    s_wt = tot_wt; s_act = tot_act; s_res = tot_res; s_done = tot_done;
    bus.start_in     = 1'b1;
    bus.batch_len_in = BW'(len);
`ifdef SA_CTRL_WEIGHT_REUSE_EN
    bus.reuse_weights_in = reuse;
`endif
    @(posedge clk);
    #1;
    bus.start_in     = 1'b0;
    bus.batch_len_in = BW'($urandom);
`ifdef SA_CTRL_WEIGHT_REUSE_EN
    bus.reuse_weights_in = 1'($urandom);
`endif
    chk_eq("busy_after_start", 128'(bus.busy_out), 128'(1));
    got = 1'b0;
    for (int i = 0; i < 4000 && !got; i++) begin
      @(posedge clk);
      #1;
      if (poke && i == 3) begin
        bus.start_in     = 1'b1;
        bus.batch_len_in = BW'(len + 7);
      end else begin
        bus.start_in = 1'b0;
      end
      if (tot_done != s_done) got = 1'b1;
    end
    bus.start_in = 1'b0;
    chk_eq("done_seen", 128'(got), 128'(1));
    repeat (3) @(posedge clk);
    #1;
    chk_eq("done_count", 128'(tot_done - s_done), 128'(1));
    chk_eq("wt_rows",    128'(tot_wt - s_wt),     128'(exp_wt));
    chk_eq("act_count",  128'(tot_act - s_act),   128'(len));
    chk_eq("res_count",  128'(tot_res - s_res),   128'(len));
    chk_eq("busy_idle",  128'(bus.busy_out),      128'(0));
    if (len > 0) begin
      chk_eq("done_after_res", 128'(done_cyc - last_res_cyc),     128'(1));
      chk_eq("res_latency",    128'(last_res_cyc - last_act_cyc), 128'(D));
    end
  endtask

  initial begin
    int s_done, s_act, s_res;
    bus.start_in     = 1'b0;
    bus.batch_len_in = '0;
`ifdef SA_CTRL_WEIGHT_REUSE_EN
    bus.reuse_weights_in = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_reset_outputs();

    run_job(4, 100, 1'b0, 1'b0, ROWS);
    act_pat = 1'b1;
    run_job(1, 100, 1'b0, 1'b0, ROWS);
    act_pat = 1'b0;
    run_job(0, 100, 1'b0, 1'b0, ROWS);
    for (int j = 0; j < 3; j++) run_job(int'($urandom_range(20, 1)), 50, 1'b0, 1'b0, ROWS);
    run_job(10, 50, 1'b1, 1'b0, ROWS);

    // Abort a job mid-stream
    wt_pct  = 100;
    act_pct = 100;
    @(posedge clk);
    #1;
    s_done = tot_done; s_act = tot_act; s_res = tot_res;
    bus.start_in     = 1'b1;
    bus.batch_len_in = BW'(40);
    @(posedge clk);
    #1;
    bus.start_in = 1'b0;
    for (int i = 0; i < 200 && (tot_act - s_act) < 5; i++) @(posedge clk);
    #1;
    chk_eq("abort_streaming", 128'((tot_act - s_act) >= 5), 128'(1));
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_reset_outputs();
    repeat (30) @(posedge clk);
    #1;
    chk_eq("abort_no_done", 128'(tot_done - s_done), 128'(0));
    chk_eq("abort_no_res",  128'(tot_res - s_res),   128'(0));

    run_job(3, 100, 1'b0, 1'b1, ROWS);
    run_job(5, 50, 1'b0, 1'b1, REUSE_WT);
    run_job(255, 50, 1'b0, 1'b0, ROWS);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
